// File: rtl/block_row_ctrl.sv
// Controller for a horizontal row of brick blocks: per-pixel draw with bump offset,
// Mario-vs-row collision classification and multi-hit breaking, all advanced on a synced frame tick.
module block_row_ctrl #(
    parameter int NUM_BLOCKS    = 4,
    parameter int BLOCK_SIZE    = 32,
    parameter int MARIO_SIZE    = 32,
    parameter int HITS_TO_BREAK = 1,
    parameter int BUMP_FRAMES   = 8,
    parameter int BUMP_HEIGHT   = 4,
    parameter int HEAD_WINDOW   = 8,
    parameter int LAND_WINDOW   = 4,
    localparam int IDX_W        = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  frame_clk,
    input  logic [9:0]            DrawX,
    input  logic [9:0]            DrawY,
    input  logic [9:0]            RowX,
    input  logic [9:0]            RowY,
    input  logic [9:0]            MarioX,
    input  logic [9:0]            MarioY,
    input  logic                  Mario_Rising,
    output logic                  Is_Block,
    output logic [IDX_W-1:0]      Draw_Index,
    output logic [2:0]            Mario_Collision,
    output logic                  Hit_Pulse,
    output logic [IDX_W-1:0]      Hit_Index,
    output logic                  Break_Pulse,
    output logic [NUM_BLOCKS-1:0] Broken_Mask
);

    localparam int SHIFT  = $clog2(BLOCK_SIZE);
    localparam int BUMP_W = (BUMP_FRAMES > 1) ? $clog2(BUMP_FRAMES + 1) : 1;

    // One spare bit beyond the 11-bit range keeps MarioX+MARIO_SIZE from wrapping near the screen edge.
    typedef logic signed [11:0] pos_t;

    localparam pos_t ROW_W  = pos_t'(NUM_BLOCKS * BLOCK_SIZE);
    localparam pos_t BS_P   = pos_t'(BLOCK_SIZE);
    localparam pos_t MS_P   = pos_t'(MARIO_SIZE);
    localparam pos_t HALF_M = pos_t'(MARIO_SIZE / 2);
    localparam pos_t HW_P   = pos_t'(HEAD_WINDOW);
    localparam pos_t LW_P   = pos_t'(LAND_WINDOW);
    localparam pos_t BH_P   = pos_t'(BUMP_HEIGHT);
    localparam logic [2:0]        HITS_LIM  = 3'(HITS_TO_BREAK);
    localparam logic [BUMP_W-1:0] BUMP_LOAD = BUMP_W'(BUMP_FRAMES);

    function automatic pos_t to_pos(input logic [9:0] v);
        return pos_t'({2'b00, v});
    endfunction

    function automatic logic in_row(input pos_t x, input pos_t row_x);
        pos_t rel;
        rel = x - row_x;
        return (rel >= 12'sd0) && (rel < ROW_W);
    endfunction

    function automatic logic [IDX_W-1:0] idx_of(input pos_t x, input pos_t row_x);
        pos_t rel;
        rel = x - row_x;
        return IDX_W'(rel >>> SHIFT);
    endfunction

    logic [2:0]            sync_r;
    logic                  tick_r;
    logic [2:0]            coll_r;
    logic                  hit_pulse_r;
    logic [IDX_W-1:0]      hit_idx_r;
    logic                  break_pulse_r;
    logic [NUM_BLOCKS-1:0] broken_r;
    logic [2:0]            hit_cnt_r [NUM_BLOCKS];
    logic [BUMP_W-1:0]     bump_cnt_r;
    logic [IDX_W-1:0]      bump_idx_r;

    pos_t mx_s, my_s, rx_s, ry_s, dx_s, dy_s, cx_s, xr_s;
    assign mx_s = to_pos(MarioX);
    assign my_s = to_pos(MarioY);
    assign rx_s = to_pos(RowX);
    assign ry_s = to_pos(RowY);
    assign dx_s = to_pos(DrawX);
    assign dy_s = to_pos(DrawY);
    assign cx_s = mx_s + HALF_M;
    assign xr_s = mx_s + MS_P - 12'sd1;

    logic             c_valid_s, r_valid_s, l_valid_s, d_valid_s;
    logic [IDX_W-1:0] c_idx_s, r_idx_s, l_idx_s, d_idx_s;
    assign c_valid_s = in_row(cx_s, rx_s);
    assign c_idx_s   = idx_of(cx_s, rx_s);
    assign r_valid_s = in_row(xr_s, rx_s);
    assign r_idx_s   = idx_of(xr_s, rx_s);
    assign l_valid_s = in_row(mx_s, rx_s);
    assign l_idx_s   = idx_of(mx_s, rx_s);
    assign d_valid_s = in_row(dx_s, rx_s);
    assign d_idx_s   = idx_of(dx_s, rx_s);

    logic c_open_s, head_s, top_s, overlap_s, left_s, right_s;
    assign c_open_s  = c_valid_s && !broken_r[c_idx_s];
    assign head_s    = c_open_s && Mario_Rising && (my_s > ry_s + BS_P - HW_P) && (my_s <= ry_s + BS_P);
    assign top_s     = c_open_s && !Mario_Rising && (my_s + MS_P >= ry_s - LW_P) && (my_s + MS_P <= ry_s);
    assign overlap_s = (my_s + MS_P > ry_s) && (my_s < ry_s + BS_P);
    assign left_s    = overlap_s && r_valid_s && !broken_r[r_idx_s] && (!c_valid_s || (r_idx_s != c_idx_s));
    assign right_s   = overlap_s && l_valid_s && !broken_r[l_idx_s] && (!c_valid_s || (l_idx_s != c_idx_s));

    logic [2:0] coll_s;
    logic       accept_s, break_s;

    // Collision priority: head > top > Mario-left-of-block > Mario-right-of-block.
    always_comb begin
        coll_s = 3'd0;
        if (head_s) begin
            coll_s = 3'd2;
        end else if (top_s) begin
            coll_s = 3'd4;
        end else if (left_s) begin
            coll_s = 3'd3;
        end else if (right_s) begin
            coll_s = 3'd1;
        end else begin
            coll_s = 3'd0;
        end
    end

    assign accept_s = tick_r && (coll_s == 3'd2) && (bump_cnt_r == {BUMP_W{1'b0}});
    assign break_s  = accept_s && ((hit_cnt_r[c_idx_s] + 3'd1) == HITS_LIM);

    pos_t draw_top_s;
    logic draw_hit_s;

    // Pixel ownership; the bumping block is drawn raised by BUMP_HEIGHT.
    always_comb begin
        draw_top_s = ry_s;
        if ((bump_cnt_r != {BUMP_W{1'b0}}) && (bump_idx_r == d_idx_s)) begin
            draw_top_s = ry_s - BH_P;
        end else begin
            draw_top_s = ry_s;
        end
        draw_hit_s = d_valid_s && !broken_r[d_idx_s] && (dy_s >= draw_top_s) && (dy_s < draw_top_s + BS_P);
    end

    assign Is_Block        = draw_hit_s;
    assign Draw_Index      = draw_hit_s ? d_idx_s : {IDX_W{1'b0}};
    assign Mario_Collision = coll_r;
    assign Hit_Pulse       = hit_pulse_r;
    assign Hit_Index       = hit_idx_r;
    assign Break_Pulse     = break_pulse_r;
    assign Broken_Mask     = broken_r;

    // frame_clk two-flop synchroniser plus registered rising-edge detect.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync_r <= 3'b000;
            tick_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[1:0], frame_clk};
            tick_r <= sync_r[1] & ~sync_r[2];
        end
    end

    // Per-frame state: collision code, hit counters, shared bump counter, broken mask and pulses.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            coll_r        <= 3'd0;
            hit_pulse_r   <= 1'b0;
            hit_idx_r     <= {IDX_W{1'b0}};
            break_pulse_r <= 1'b0;
            broken_r      <= {NUM_BLOCKS{1'b0}};
            bump_cnt_r    <= {BUMP_W{1'b0}};
            bump_idx_r    <= {IDX_W{1'b0}};
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                hit_cnt_r[i] <= 3'd0;
            end
        end else begin
            hit_pulse_r   <= accept_s;
            break_pulse_r <= break_s;
            hit_idx_r     <= accept_s ? c_idx_s : {IDX_W{1'b0}};
            if (tick_r) begin
                coll_r <= coll_s;
                if (accept_s && !break_s) begin
                    bump_cnt_r <= BUMP_LOAD;
                    bump_idx_r <= c_idx_s;
                end else if (bump_cnt_r != {BUMP_W{1'b0}}) begin
                    bump_cnt_r <= bump_cnt_r - {{(BUMP_W-1){1'b0}}, 1'b1};
                end
            end
            if (accept_s) begin
                hit_cnt_r[c_idx_s] <= hit_cnt_r[c_idx_s] + 3'd1;
                if (break_s) begin
                    broken_r[c_idx_s] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_block_row_ctrl.sv
// Self-checking bench: two controllers (1-hit and 3-hit break) share stimulus and are
// compared each cycle against a frame-level behavioural model of the row.
module tb_block_row_ctrl;

    logic Clk = 1'b0, Reset = 1'b0, frame_clk = 1'b0, clk_en = 1'b0, Mario_Rising = 1'b0;
    logic [9:0] DrawX, DrawY, RowX, RowY, MarioX, MarioY;

    logic       ib1, ib3, hp1, hp3, bp1, bp3;
    logic [1:0] di1, di3, hi1, hi3;
    logic [2:0] mc1, mc3;
    logic [3:0] bm1, bm3;

    block_row_ctrl #(.NUM_BLOCKS(4), .BLOCK_SIZE(32), .MARIO_SIZE(32), .HITS_TO_BREAK(1),
                     .BUMP_FRAMES(8), .BUMP_HEIGHT(4), .HEAD_WINDOW(8), .LAND_WINDOW(4)) u1 (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .DrawX(DrawX), .DrawY(DrawY),
        .RowX(RowX), .RowY(RowY), .MarioX(MarioX), .MarioY(MarioY), .Mario_Rising(Mario_Rising),
        .Is_Block(ib1), .Draw_Index(di1), .Mario_Collision(mc1), .Hit_Pulse(hp1),
        .Hit_Index(hi1), .Break_Pulse(bp1), .Broken_Mask(bm1));

    block_row_ctrl #(.NUM_BLOCKS(4), .BLOCK_SIZE(32), .MARIO_SIZE(32), .HITS_TO_BREAK(3),
                     .BUMP_FRAMES(8), .BUMP_HEIGHT(4), .HEAD_WINDOW(8), .LAND_WINDOW(4)) u3 (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .DrawX(DrawX), .DrawY(DrawY),
        .RowX(RowX), .RowY(RowY), .MarioX(MarioX), .MarioY(MarioY), .Mario_Rising(Mario_Rising),
        .Is_Block(ib3), .Draw_Index(di3), .Mario_Collision(mc3), .Hit_Pulse(hp3),
        .Hit_Index(hi3), .Break_Pulse(bp3), .Broken_Mask(bm3));

    always begin
        #5;
        if (clk_en) Clk = ~Clk;
    end

    int n_chk = 0, n_fail = 0;
    int n_hp1 = 0, n_hp3 = 0, n_bp1 = 0, n_bp3 = 0, last_hi1 = -1;
    bit chk_en = 1'b0;

    // Frame-level model state, index 0 = 1-hit instance, 1 = 3-hit instance.
    int hits[2] = '{1, 3};
    int m_cnt[2][4], m_brk[2][4];
    int m_bump[2], m_bidx[2], m_coll[2], m_hit[2], m_hidx[2], m_bp[2];
    int cd = 0;
    bit fc_prev = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ix(input int x);
        int rel = x - int'(RowX);
        if (rel < 0 || rel >= 128) return -1;
        return rel / 32;
    endfunction

    function automatic bit open_blk(input int d, input int i);
        return (i >= 0) && (m_brk[d][i] == 0);
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) begin m_cnt[d][i] = 0; m_brk[d][i] = 0; end
            m_bump[d] = 0; m_bidx[d] = 0; m_coll[d] = 0; m_hit[d] = 0; m_hidx[d] = 0; m_bp[d] = 0;
        end
    endtask

    task automatic model_frame(input int d);
        int mx = int'(MarioX), my = int'(MarioY), ry = int'(RowY);
        int c = ix(mx + 16), r = ix(mx + 31), l = ix(mx);
        bit ov = (my + 32 > ry) && (my < ry + 32);
        int code = 0;
        if (open_blk(d, c) && Mario_Rising && my > ry + 24 && my <= ry + 32) code = 2;
        else if (open_blk(d, c) && !Mario_Rising && my + 32 >= ry - 4 && my + 32 <= ry) code = 4;
        else if (ov && open_blk(d, r) && r != c) code = 3;
        else if (ov && open_blk(d, l) && l != c) code = 1;
        m_coll[d] = code;
        if (code == 2 && m_bump[d] == 0) begin
            m_hit[d] = 1; m_hidx[d] = c; m_cnt[d][c]++;
            if (m_cnt[d][c] == hits[d]) begin m_brk[d][c] = 1; m_bp[d] = 1; end
            else begin m_bump[d] = 8; m_bidx[d] = c; end
        end else if (m_bump[d] > 0) begin
            m_bump[d]--;
        end
    endtask

    task automatic cmp(input int d, input logic ib, input logic [1:0] di, input logic [2:0] mc,
                       input logic hp, input logic [1:0] hi, input logic bp, input logic [3:0] bm);
        int e_is = 0, e_idx = 0, e_mask = 0;
        for (int i = 0; i < 4; i++) begin
            int off = (m_bump[d] > 0 && m_bidx[d] == i) ? 4 : 0;
            int x0 = int'(RowX) + 32 * i, y0 = int'(RowY) - off;
            if (m_brk[d][i] == 0 && int'(DrawX) >= x0 && int'(DrawX) < x0 + 32 &&
                int'(DrawY) >= y0 && int'(DrawY) < y0 + 32) begin
                e_is = 1; e_idx = i;
            end
            if (m_brk[d][i] != 0) e_mask |= (1 << i);
        end
        chk($sformatf("inst%0d Is_Block", d), int'(ib), e_is);
        chk($sformatf("inst%0d Draw_Index", d), int'(di), e_idx);
        chk($sformatf("inst%0d Mario_Collision", d), int'(mc), m_coll[d]);
        chk($sformatf("inst%0d Hit_Pulse", d), int'(hp), m_hit[d]);
        if (m_hit[d] != 0) chk($sformatf("inst%0d Hit_Index", d), int'(hi), m_hidx[d]);
        chk($sformatf("inst%0d Break_Pulse", d), int'(bp), m_bp[d]);
        chk($sformatf("inst%0d Broken_Mask", d), int'(bm), e_mask);
    endtask

    // Model: frame tick lands 3 Clk after the frame_clk edge, state moves on the following edge.
    initial begin
        model_clear();
        forever begin
            @(posedge Clk or posedge Reset);
            if (Reset) begin
                model_clear(); cd = 0; fc_prev = 1'b0;
            end else begin
                for (int d = 0; d < 2; d++) begin m_hit[d] = 0; m_bp[d] = 0; end
                if (cd == 1) for (int d = 0; d < 2; d++) model_frame(d);
                if (cd != 0) cd--;
                if (frame_clk && !fc_prev) cd = 3;
                fc_prev = frame_clk;
            end
        end
    end

    // Cycle compare plus pulse bookkeeping for the literal checks.
    initial begin
        forever begin
            @(posedge Clk);
            #2;
            if (chk_en) begin
                cmp(0, ib1, di1, mc1, hp1, hi1, bp1, bm1);
                cmp(1, ib3, di3, mc3, hp3, hi3, bp3, bm3);
            end
            if (hp1) begin n_hp1++; last_hi1 = int'(hi1); end
            if (hp3) n_hp3++;
            if (bp1) n_bp1++;
            if (bp3) n_bp3++;
        end
    end

    task automatic frame(input logic rising);
        @(negedge Clk);
        Mario_Rising = rising;
        frame_clk = 1'b1;
        repeat (6) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic do_reset();
        @(negedge Clk); Reset = 1'b1;
        @(negedge Clk); Reset = 1'b0;
    endtask

    task automatic zero_counts();
        n_hp1 = 0; n_hp3 = 0; n_bp1 = 0; n_bp3 = 0; last_hi1 = -1;
    endtask

    initial begin
        RowX = 10'd200; RowY = 10'd300; DrawX = 10'd200; DrawY = 10'd300;
        MarioX = 10'd0; MarioY = 10'd0;
        // 1: reset with no clock running
        #3 Reset = 1'b1;
        #2;
        chk("t1 mask no clk", int'(bm1), 0);
        chk("t1 coll no clk", int'(mc3), 0);
        clk_en = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        chk_en = 1'b1;
        @(negedge Clk);
        chk("t1 Is_Block", int'(ib1), 1);
        chk("t1 Draw_Index", int'(di1), 0);

        // 2: single-hit break of block 1
        zero_counts();
        MarioX = 10'd232; MarioY = 10'd325;
        frame(1'b1);
        chk("t2 coll", int'(mc1), 2);
        chk("t2 hit count", n_hp1, 1);
        chk("t2 break count", n_bp1, 1);
        chk("t2 hit index", last_hi1, 1);
        chk("t2 mask", int'(bm1), 4'b0010);
        DrawX = 10'd240; DrawY = 10'd310;
        @(negedge Clk);
        chk("t2 broken not drawn", int'(ib1), 0);

        // 3: three accepted hits on block 2 for the 3-hit instance
        do_reset();
        zero_counts();
        MarioX = 10'd264; MarioY = 10'd325; DrawX = 10'd270; DrawY = 10'd297;
        frame(1'b1);
        chk("t3 raised after hit", int'(ib3), 1);
        for (int k = 2; k <= 9; k++) begin
            frame(k == 3);
            if (k == 3) begin
                chk("t3 coll during bump", int'(mc3), 2);
                chk("t3 no accept during bump", n_hp3, 1);
            end
            if (k == 8) chk("t3 still raised frame 8", int'(ib3), 1);
        end
        chk("t3 lowered after 8 frames", int'(ib3), 0);
        frame(1'b1);
        for (int k = 0; k < 8; k++) frame(1'b0);
        frame(1'b1);
        chk("t3 accepted hits", n_hp3, 3);
        chk("t3 mask", int'(bm3), 4'b0100);

        // 4: landing on top, then onto a broken block
        MarioY = 10'd266;
        frame(1'b0);
        chk("t4 broken top", int'(mc3), 0);
        do_reset();
        frame(1'b0);
        chk("t4 top", int'(mc3), 4);
        chk("t4 top inst1", int'(mc1), 4);

        // 5: side contacts and off-row positions
        do_reset();
        MarioY = 10'd300;
        MarioX = 10'd170; frame(1'b0);
        chk("t5 left side", int'(mc1), 3);
        MarioX = 10'd318; frame(1'b0);
        chk("t5 right side", int'(mc3), 1);
        MarioX = 10'd120; frame(1'b0);
        chk("t5 clear", int'(mc1), 0);

        // 6: reset during a bump
        do_reset();
        MarioX = 10'd264; MarioY = 10'd325; DrawX = 10'd270; DrawY = 10'd297;
        frame(1'b1);
        frame(1'b0);
        frame(1'b0);
        chk("t6 raised before reset", int'(ib3), 1);
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        chk("t6 offset cleared", int'(ib3), 0);
        chk("t6 mask cleared", int'(bm1), 0);
        DrawY = 10'd300;
        #1;
        chk("t6 drawn at rest", int'(ib3), 1);
        @(negedge Clk);
        Reset = 1'b0;
        zero_counts();
        repeat (3) frame(1'b0);
        chk("t6 no stray hit", n_hp3 + n_hp1, 0);
        frame(1'b1);
        chk("t6 new hit", n_hp3, 1);

        repeat (2) @(negedge Clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
